// File: rtl/acq_pkg.sv
// acq_pkg: command codes, sequencer states and period clamp shared by the acquisition sequencer
package acq_pkg;
  localparam logic [7:0] CMD_START      = 8'h01;
  localparam logic [7:0] CMD_STOP       = 8'h02;
  localparam logic [7:0] CMD_SET_RECV   = 8'h03;
  localparam logic [7:0] CMD_SET_PERIOD = 8'h04;
  localparam logic [7:0] CMD_SET_SRC    = 8'h05;
  localparam logic [31:0] MIN_PERIOD    = 32'd1000;
  typedef enum logic [1:0] {IDLE, ARM, FIRE, CAPTURE} state_t;
endpackage

// File: rtl/acq_sequencer_sync_edge.sv
// sync_edge: 2-FF synchronizer plus registered rising-edge pulse (clk, rst_n, async d in, one-cycle rise out)
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      rise <= 1'b0;
    end else begin
      sr <= {sr[1:0], d};
      rise <= sr[1] & ~sr[2];
    end
endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: host-commanded shot sequencer (cmd strobe/code/param, ext trigger, AD busy, USB full in; o_st, recv count, busy, frame count, timeout flag, LEDs out)
module acq_sequencer
  import acq_pkg::*;
#(
  parameter logic [15:0] DEF_RECV_COUNT = 16'd9000,
  parameter logic [31:0] DEF_PERIOD     = 32'd100000,
  parameter logic [31:0] MIN_PERIOD     = acq_pkg::MIN_PERIOD,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic        i_cmd_come,
  input  logic [7:0]  i_cmd,
  input  logic [31:0] i_cmd_param,
  input  logic        i_ext_trig,
  input  logic        i_ad_working,
  input  logic        i_usb_full,
  output logic        o_st,
  output logic [15:0] o_recv_count,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic        o_err_timeout,
  output logic [3:0]  o_led
);
  state_t state, nxt;
  logic [31:0] period, pcnt, tcnt;
  logic [15:0] target;
  logic ext_src, seen, ext_rise, trig, done, fin, tmo, start, stop, cap_led;
  sync_edge u_sync (
    .clk(i_clk_sys),
    .rst_n(i_rst_n),
    .d(i_ext_trig),
    .rise(ext_rise)
  );
  assign start = i_cmd_come && i_cmd == CMD_START && state == IDLE;
  assign stop = i_cmd_come && i_cmd == CMD_STOP;
  assign trig = ext_src ? ext_rise : pcnt >= period - 32'd1;
  assign done = seen && !i_ad_working;
  assign fin = state == CAPTURE && done;
  assign tmo = state == CAPTURE && !done && tcnt >= TIMEOUT_CYCLES - 32'd1;
  assign o_led = {o_err_timeout, ext_src, cap_led, o_busy};
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ARM : IDLE;
      ARM:     nxt = trig && !i_usb_full ? FIRE : ARM;
      FIRE:    nxt = CAPTURE;
      CAPTURE: nxt = fin ? (target != '0 && o_frame_cnt + 16'd1 == target ? IDLE : ARM) : tmo ? IDLE : CAPTURE;
      default: nxt = IDLE;
    endcase
    if (stop) nxt = IDLE;
  end
  always_ff @(posedge i_clk_sys or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      period <= DEF_PERIOD;
      pcnt <= '0;
      tcnt <= '0;
      target <= '0;
      ext_src <= 1'b0;
      seen <= 1'b0;
      cap_led <= 1'b0;
      o_st <= 1'b0;
      o_recv_count <= DEF_RECV_COUNT;
      o_busy <= 1'b0;
      o_frame_cnt <= '0;
      o_err_timeout <= 1'b0;
    end else begin
      state <= nxt;
      o_st <= nxt == FIRE;
      o_busy <= nxt != IDLE;
      cap_led <= nxt == CAPTURE;
      pcnt <= start ? '1 : nxt == FIRE ? '0 : pcnt + {31'd0, ~&pcnt};
      tcnt <= nxt == FIRE ? '0 : tcnt + {31'd0, ~&tcnt};
      seen <= nxt == FIRE ? 1'b0 : seen | (state == CAPTURE && i_ad_working);
      o_frame_cnt <= start ? '0 : fin ? o_frame_cnt + 16'd1 : o_frame_cnt;
      o_err_timeout <= start ? 1'b0 : o_err_timeout | tmo;
      if (start) target <= i_cmd_param[15:0];
      if (i_cmd_come && i_cmd == CMD_SET_RECV && state == IDLE && i_cmd_param[15:0] != '0)
        o_recv_count <= i_cmd_param[15:0];
      if (i_cmd_come && i_cmd == CMD_SET_PERIOD)
        period <= i_cmd_param < MIN_PERIOD ? MIN_PERIOD : i_cmd_param;
      if (i_cmd_come && i_cmd == CMD_SET_SRC)
        ext_src <= i_cmd_param[0];
    end
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed self-checking bench for acq_sequencer
module tb_acq_sequencer;
  import acq_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, cmd_come = 1'b0, ext_trig = 1'b0;
  logic ad_working = 1'b0, usb_full = 1'b0, work_en = 1'b1;
  logic [7:0] cmd = '0;
  logic [31:0] cmd_param = '0;
  logic st, busy, err, t_st, t_busy, t_err;
  logic [15:0] recv, frame, t_recv, t_frame;
  logic [3:0] led, t_led;
  int cyc = 0, checks = 0, failures = 0, fall_cyc = 0;
  int st_q[$], t_q[$];

  acq_sequencer dut (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_cmd_come(cmd_come), .i_cmd(cmd),
    .i_cmd_param(cmd_param), .i_ext_trig(ext_trig), .i_ad_working(ad_working),
    .i_usb_full(usb_full), .o_st(st), .o_recv_count(recv), .o_busy(busy),
    .o_frame_cnt(frame), .o_err_timeout(err), .o_led(led)
  );

  acq_sequencer #(.TIMEOUT_CYCLES(32'd100)) dut_to (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_cmd_come(cmd_come), .i_cmd(cmd),
    .i_cmd_param(cmd_param), .i_ext_trig(ext_trig), .i_ad_working(1'b0),
    .i_usb_full(usb_full), .o_st(t_st), .o_recv_count(t_recv), .o_busy(t_busy),
    .o_frame_cnt(t_frame), .o_err_timeout(t_err), .o_led(t_led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (st) st_q.push_back(cyc);
    if (t_st) t_q.push_back(cyc);
  end

  always begin
    @(negedge clk);
    if (work_en && st) begin
      repeat (2) @(negedge clk);
      ad_working = 1'b1;
      repeat (200) @(negedge clk);
      ad_working = 1'b0;
      fall_cyc = cyc;
    end
  end

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] p);
    cmd_come = 1'b1;
    cmd = c;
    cmd_param = p;
    @(negedge clk);
    cmd_come = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL reset_st got=%0b exp=0", st); end
    checks++; if (recv !== 16'd9000) begin failures++; $display("FAIL reset_recv got=%0d exp=9000", recv); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (frame !== 16'd0) begin failures++; $display("FAIL reset_frame got=%0d exp=0", frame); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if (led !== 4'd0) begin failures++; $display("FAIL reset_led got=%0h exp=0", led); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frames();
    int n, t0;
    send_cmd(CMD_SET_PERIOD, 32'd1000);
    st_q.delete();
    n = cyc;
    send_cmd(CMD_START, 32'd3);
    t0 = cyc;
    while (busy && cyc - t0 < 5000) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frames_done busy got=%0b exp=0", busy); end
    checks++; if (st_q.size() != 3) begin failures++; $display("FAIL frames_pulses got=%0d exp=3", st_q.size()); end
    if (st_q.size() == 3) begin
      checks++; if (st_q[0] != n + 2) begin failures++; $display("FAIL frames_latency got=%0d exp=%0d", st_q[0], n + 2); end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (st_q[i] - st_q[i-1] != 1000) begin failures++; $display("FAIL frames_spacing%0d got=%0d exp=1000", i, st_q[i] - st_q[i-1]); end
      end
    end
    checks++; if (frame !== 16'd3) begin failures++; $display("FAIL frames_cnt got=%0d exp=3", frame); end
    checks++; if (cyc != fall_cyc + 1) begin failures++; $display("FAIL frames_busy_fall got=%0d exp=%0d", cyc, fall_cyc + 1); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_recv_count();
    send_cmd(CMD_SET_RECV, 32'd5000);
    checks++; if (recv !== 16'd5000) begin failures++; $display("FAIL recv_idle got=%0d exp=5000", recv); end
    send_cmd(CMD_START, 32'd0);
    send_cmd(CMD_SET_RECV, 32'd7000);
    checks++; if (recv !== 16'd5000) begin failures++; $display("FAIL recv_busy got=%0d exp=5000", recv); end
    send_cmd(CMD_STOP, 32'd0);
    send_cmd(CMD_SET_RECV, 32'd0);
    checks++; if (recv !== 16'd5000) begin failures++; $display("FAIL recv_zero got=%0d exp=5000", recv); end
    repeat (250) @(negedge clk);
  endtask

  task automatic test_period_clamp();
    int t0;
    send_cmd(CMD_SET_PERIOD, 32'd5000);
    send_cmd(CMD_SET_PERIOD, 32'd10);
    st_q.delete();
    send_cmd(CMD_START, 32'd2);
    t0 = cyc;
    while (busy && cyc - t0 < 5000) @(negedge clk);
    checks++; if (st_q.size() != 2) begin failures++; $display("FAIL clamp_pulses got=%0d exp=2", st_q.size()); end
    if (st_q.size() == 2) begin
      checks++; if (st_q[1] - st_q[0] != 1000) begin failures++; $display("FAIL clamp_spacing got=%0d exp=1000", st_q[1] - st_q[0]); end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_ext_trigger();
    int e[3];
    send_cmd(CMD_SET_SRC, 32'd1);
    st_q.delete();
    send_cmd(CMD_START, 32'd0);
    for (int i = 0; i < 3; i++) begin
      repeat (20) @(negedge clk);
      e[i] = cyc;
      ext_trig = 1'b1;
      repeat (5) @(negedge clk);
      ext_trig = 1'b0;
      if (i == 0) begin
        while (cyc < e[i] + 50) @(negedge clk);
        ext_trig = 1'b1;
        repeat (5) @(negedge clk);
        ext_trig = 1'b0;
      end
      while (cyc < e[i] + 3000) @(negedge clk);
    end
    checks++; if (st_q.size() != 3) begin failures++; $display("FAIL ext_pulses got=%0d exp=3", st_q.size()); end
    if (st_q.size() == 3)
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (st_q[i] != e[i] + 4) begin failures++; $display("FAIL ext_latency%0d got=%0d exp=%0d", i, st_q[i], e[i] + 4); end
      end
    checks++; if (led !== 4'b0101) begin failures++; $display("FAIL ext_led got=%0h exp=5", led); end
    send_cmd(CMD_STOP, 32'd0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ext_stop got=%0b exp=0", busy); end
    send_cmd(CMD_SET_SRC, 32'd0);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_usb_full();
    int r;
    usb_full = 1'b1;
    st_q.delete();
    send_cmd(CMD_START, 32'd0);
    repeat (5000) @(negedge clk);
    checks++; if (st_q.size() != 0) begin failures++; $display("FAIL usb_hold got=%0d exp=0", st_q.size()); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL usb_busy got=%0b exp=1", busy); end
    r = cyc;
    usb_full = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ((st_q.size() == 1 ? st_q[0] : -1) != r + 1) begin failures++; $display("FAIL usb_release got=%0d exp=%0d", st_q.size() == 1 ? st_q[0] : -1, r + 1); end
    send_cmd(CMD_STOP, 32'd0);
    repeat (250) @(negedge clk);
  endtask

  task automatic test_timeout();
    int f;
    work_en = 1'b0;
    t_q.delete();
    f = cyc + 2;
    send_cmd(CMD_START, 32'd1);
    while (cyc < f + 99) @(negedge clk);
    checks++;
    if ((t_q.size() == 1 ? t_q[0] : -1) != f) begin failures++; $display("FAIL timeout_fire got=%0d exp=%0d", t_q.size() == 1 ? t_q[0] : -1, f); end
    checks++; if (t_busy !== 1'b1) begin failures++; $display("FAIL timeout_early got=%0b exp=1", t_busy); end
    @(negedge clk);
    checks++; if (t_busy !== 1'b0) begin failures++; $display("FAIL timeout_idle got=%0b exp=0", t_busy); end
    checks++; if (t_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%0b exp=1", t_err); end
    checks++; if (t_led !== 4'b1000) begin failures++; $display("FAIL timeout_led got=%0h exp=8", t_led); end
    send_cmd(CMD_STOP, 32'd0);
    send_cmd(CMD_START, 32'd1);
    checks++; if (t_err !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%0b exp=0", t_err); end
    send_cmd(CMD_STOP, 32'd0);
    work_en = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    send_cmd(CMD_START, 32'd0);
    @(negedge clk);
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL mid_fire got=%0b exp=1", st); end
    rst_n = 1'b0;
    #1;
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL mid_st got=%0b exp=0", st); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", busy); end
    checks++; if (recv !== 16'd9000) begin failures++; $display("FAIL mid_recv got=%0d exp=9000", recv); end
    checks++; if (led !== 4'd0) begin failures++; $display("FAIL mid_led got=%0h exp=0", led); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frames();
    test_recv_count();
    test_period_clamp();
    test_ext_trigger();
    test_usb_full();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Acquisition sequencer on the 100 MHz system clock. It decodes host commands delivered by the USB block and configures the AD capture front end (receive count, trigger source, shot period). It also sequences each shot: it issues the start pulse to the AD wrapper, waits for capture to finish, counts frames and holds off when the USB path is full. It replaces the free-running trigger-to-capture wiring with a host-controlled, bounded-frame acquisition.

## Interface
Parameters:
- DEF_RECV_COUNT, 16'd9000, receive count after reset
- DEF_PERIOD, 32'd100000, internal shot period in clocks after reset (1 ms)
- MIN_PERIOD, 32'd1000, lower clamp for SET_PERIOD
- TIMEOUT_CYCLES, 32'd2000000, maximum clocks spent in CAPTURE

Ports:
- i_clk_sys  in  1  system clock, 100 MHz; the only clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_cmd_come  in  1  one-cycle strobe: i_cmd/i_cmd_param valid
- i_cmd  in  8  command code
- i_cmd_param  in  32  command parameter
- i_ext_trig  in  1  external trigger, asynchronous, rising-edge active
- i_ad_working  in  1  AD wrapper capture in progress
- i_usb_full  in  1  USB write FIFO full
- o_st  out  1  one-cycle start pulse to the AD wrapper
- o_recv_count  out  16  samples per shot, to the AD wrapper
- o_busy  out  1  state != IDLE
- o_frame_cnt  out  16  frames completed since last START
- o_err_timeout  out  1  sticky capture-timeout flag
- o_led  out  4  {o_err_timeout, ext_src, state==CAPTURE, o_busy}

## Operation
- Commands (only when i_cmd_come=1; unknown codes ignored):
  - 0x01 START: param[15:0] = frame target; 0 means continuous. Accepted in IDLE only. Clears o_frame_cnt and o_err_timeout, then goes to ARM.
  - 0x02 STOP: any state goes to IDLE next cycle. If STOP arrives in FIRE, the o_st pulse of that cycle still occurs.
  - 0x03 SET_RECV_COUNT: param[15:0]. Accepted in IDLE only. A value of 0 is ignored.
  - 0x04 SET_PERIOD: period = max(param, MIN_PERIOD). Accepted in any state; takes effect at the next ARM evaluation.
  - 0x05 SET_TRIG_SRC: ext_src = param[0]. Accepted in any state.
- Period counter: 32-bit, counts clocks since the last FIRE and saturates at all-ones. It is preset to all-ones on START, so the first internal shot fires immediately.
- States:
  - IDLE: o_busy=0.
  - ARM: fires when !i_usb_full and a trigger is present. The trigger is period counter ≥ period−1 when ext_src=0, or a registered ext rising edge when ext_src=1. It then goes to FIRE.
  - FIRE: o_st=1 for this cycle only; period counter reset to 0; timeout counter reset; next state CAPTURE.
  - CAPTURE: wait for i_ad_working to rise, then fall. On the fall, o_frame_cnt increments (16-bit wrap). The next state is IDLE if the target is nonzero and the new count equals the target; otherwise ARM.
  - Timeout: if the timeout counter reaches TIMEOUT_CYCLES in CAPTURE, set o_err_timeout and go to IDLE.
- External trigger edges arriving outside ARM are dropped, not queued.
- i_usb_full only gates ARM; a capture already in progress is never aborted by it.

## Timing
- Reset values: o_st=0, o_recv_count=DEF_RECV_COUNT, o_busy=0, o_frame_cnt=0, o_err_timeout=0, o_led=0, period=DEF_PERIOD, ext_src=0, state=IDLE.
- All outputs are registered.
- START (internal source) with i_cmd_come at cycle N: ARM at N+1, o_st high during N+2, CAPTURE from N+3.
- External source: 2-FF synchronizer plus an edge register. o_st is high 4 clocks (+1 for asynchronous sampling) after i_ext_trig rises while in ARM.
- Steady-state internal shot spacing equals exactly `period` clocks, FIRE to FIRE, provided capture finishes and the USB is not full in time. If capture runs past that, the next shot fires in the ARM cycle after CAPTURE exits.
- o_frame_cnt updates 1 cycle after the i_ad_working falling edge is sampled.
- Reset asserted mid-operation returns all state to reset values immediately; o_st is forced to 0.

## Structure
- Package acq_pkg holds:
  - command codes CMD_START/STOP/SET_RECV/SET_PERIOD/SET_SRC
  - the state enum IDLE/ARM/FIRE/CAPTURE
  - MIN_PERIOD
- Sub-module sync_edge: 2-FF synchronizer plus rising-edge detector for i_ext_trig; reused by future asynchronous inputs.

## Test plan
- Reset, then START param=3, internal source, period=1000, i_ad_working modelled as a 200-clock pulse starting 2 clocks after o_st:
  - exactly 3 o_st pulses, 1000 clocks apart;
  - o_frame_cnt=3;
  - o_busy falls after the 3rd working fall.
- SET_RECV_COUNT 5000 in IDLE → o_recv_count=5000. SET_RECV_COUNT 7000 while busy → stays 5000. SET_RECV_COUNT 0 in IDLE → stays 5000.
- SET_PERIOD 10 → effective period 1000; shot spacing measured as 1000.
- ext_src=1, START param=0, i_ext_trig edges every 3000 clocks plus one extra edge during CAPTURE:
  - one o_st per edge seen in ARM;
  - the edge during CAPTURE produces no pulse;
  - STOP → IDLE next cycle.
- i_usb_full held high in ARM for 5000 clocks → no o_st. Release → o_st within 2 clocks.
- i_ad_working stuck low after o_st, TIMEOUT_CYCLES=100 → o_err_timeout=1 and IDLE 100 clocks after FIRE. A following START clears o_err_timeout.
